// File: rtl/spm_pkg.sv
// Shared definitions for the serial-parallel multiplier.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package spm_pkg;

   // Default operand width in bits.
   localparam int SPM_WIDTH = 32;

   // Sequencer states. IDLE accepts operands, RUN shifts the multiplier, DONE holds the product.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/spm_cell.sv
// One carry-save bit-cell of the serial-parallel array: adds the incoming sum, its partial product and its own carry.
// Latency: 1 cycle (sum and carry registered); the next sum is also exposed combinationally.
// Backpressure: none; the cell only advances while en is high.
module spm_cell (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic sin,
   input  logic pp,
   output logic sum,
   output logic sum_nxt
);

   logic carry;
   logic carry_nxt;

   // Full adder. The carry stays in this cell: after the array shifts right,
   // a carry of weight 2^(i+1) lands back on weight 2^i.
   always_comb begin
      sum_nxt   = sin ^ pp ^ carry;
      carry_nxt = (sin & pp) | (sin & carry) | (pp & carry);
   end

   // Registered sum/carry with async reset and synchronous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum   <= 1'b0;
         carry <= 1'b0;
      end else if (clr) begin
         sum   <= 1'b0;
         carry <= 1'b0;
      end else if (en) begin
         sum   <= sum_nxt;
         carry <= carry_nxt;
      end
   end

endmodule

// File: rtl/spm_mul.sv
// Serial-parallel multiplier: x parallel, y serial LSB-first, PW-bit product shifted into p (signed mode under SPM_SIGNED_EN).
// Latency: accept on edge k, out_valid rises after edge k+PW; one product per PW+2 cycles at best.
// Backpressure: product and out_valid hold in DONE until out_ready; in_ready stays low until the product is taken.
module spm_mul
   import spm_pkg::*;
#(
   parameter int WIDTH = SPM_WIDTH,
   // Derived product width; leave at its default.
   parameter int PW    = 2*WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             sgn,
   input  logic             clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PW-1:0]    p
);

   localparam int CW = $clog2(PW) + 1;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] xr;
   logic [WIDTH-1:0] yr;

   logic             bit_y;
   logic             top_pp;
   logic             y_fill;
   logic             run;
   logic             last;
   logic             cell_clr;
   logic             pbit;
   logic [WIDTH-1:0] pp;
   logic [WIDTH-1:0] sin;
   logic [WIDTH-1:0] sums;
   logic [WIDTH-1:0] sum_nxt;
   logic             unused_bits;

`ifdef SPM_SIGNED_EN
   logic sr;
   logic neg_seen;
   logic msb_raw;
`endif

   assign bit_y    = yr[0];
   assign run      = (state == RUN);
   assign last     = (cnt == CW'(PW - 1));
   // The accumulator is wiped on abort and on every accepted operation.
   assign cell_clr = clr | ((state == IDLE) & in_valid);

`ifdef SPM_SIGNED_EN
   // A negative multiplicand is x_low - x[W-1]*2^(W-1). The MSB cell therefore
   // adds the serial two's complement of (x[W-1] & y-stream): each bit is
   // inverted once any earlier bit of that stream was 1. All addends stay
   // non-negative, so the carry-save array is exact and p is right mod 2^PW.
   // The multiplier stream is sign-extended by refilling y with its MSB.
   always_comb begin
      msb_raw = xr[WIDTH-1] & bit_y;
      top_pp  = sr ? (msb_raw ^ neg_seen) : msb_raw;
      y_fill  = sr & yr[WIDTH-1];
   end
   assign unused_bits = ^{sum_nxt[WIDTH-1:1]};
`else
   // Unsigned only: plain MSB partial product, zero-extended multiplier, sgn ignored.
   always_comb begin
      top_pp = xr[WIDTH-1] & bit_y;
      y_fill = 1'b0;
   end
   assign unused_bits = ^{sum_nxt[WIDTH-1:1], sgn};
`endif

   assign pp   = {top_pp, xr[WIDTH-2:0] & {(WIDTH-1){bit_y}}};
   assign sin  = {1'b0, sums[WIDTH-1:1]};
   // Cell 0's fresh sum is the product bit of the current cycle.
   assign pbit = sum_nxt[0];

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_cell
         spm_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .clr     (cell_clr),
            .en      (run),
            .sin     (sin[gi]),
            .pp      (pp[gi]),
            .sum     (sums[gi]),
            .sum_nxt (sum_nxt[gi])
         );
      end
   endgenerate

   // Sequencer: operand capture, bit counter, product shift register and handshake flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         cnt       <= '0;
         xr        <= '0;
         yr        <= '0;
         p         <= '0;
`ifdef SPM_SIGNED_EN
         sr        <= 1'b0;
         neg_seen  <= 1'b0;
`endif
      end else if (clr) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         cnt       <= '0;
         p         <= '0;
`ifdef SPM_SIGNED_EN
         neg_seen  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  xr       <= x;
                  yr       <= y;
                  cnt      <= '0;
                  state    <= RUN;
                  in_ready <= 1'b0;
`ifdef SPM_SIGNED_EN
                  sr       <= sgn;
                  neg_seen <= 1'b0;
`endif
               end
            end
            RUN: begin
               p   <= {pbit, p[PW-1:1]};
               yr  <= {y_fill, yr[WIDTH-1:1]};
               cnt <= cnt + 1'b1;
`ifdef SPM_SIGNED_EN
               neg_seen <= neg_seen | msb_raw;
`endif
               if (last) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spm_mul.sv
// Self-checking bench for spm_mul at WIDTH=8: per-cycle model compare plus directed literal vectors.
// Latency: expects out_valid 16 edges after the accept edge.
// Backpressure: exercises held out_ready, abort via clr and reset mid-run.
module tb_spm_mul;

   localparam int W  = 8;
   localparam int PW = 2*W;
`ifdef SPM_SIGNED_EN
   localparam bit SIGNED_BUILD = 1'b1;
`else
   localparam bit SIGNED_BUILD = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  x;
   logic [W-1:0]  y;
   logic          sgn;
   logic          clr;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] p;

   int checks = 0;
   int errors = 0;

   spm_mul #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .sgn       (sgn),
      .clr       (clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Product the block must deliver, from plain arithmetic.
   function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      logic signed [PW-1:0] sa;
      logic signed [PW-1:0] sb;
      if (s && SIGNED_BUILD) begin
         sa = $signed(a);
         sb = $signed(b);
         return sa * sb;
      end
      return {8'h00, a} * {8'h00, b};
   endfunction

   // Transaction-level model: busy for PW cycles after an accept, then holds the product.
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;
   int            mode  = M_IDLE;
   int            left  = 0;
   logic [PW-1:0] pend  = '0;
   logic [PW-1:0] exp_p = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode  <= M_IDLE;
         exp_p <= '0;
      end else if (clr) begin
         mode  <= M_IDLE;
         exp_p <= '0;
      end else begin
         case (mode)
            M_IDLE: if (in_valid) begin
               mode <= M_RUN;
               left <= PW;
               pend <= ref_mul(x, y, sgn);
            end
            M_RUN: begin
               left <= left - 1;
               if (left == 1) begin
                  mode  <= M_DONE;
                  exp_p <= pend;
               end
            end
            default: if (out_ready) mode <= M_IDLE;
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
      end
   endtask

   // Compare DUT against the model on every falling edge.
   always @(negedge clk) begin
      chk("cyc_in_ready", 32'(in_ready), 32'(mode == M_IDLE));
      chk("cyc_out_valid", 32'(out_valid), 32'(mode == M_DONE));
      if (mode != M_RUN)
         chk("cyc_p", 32'(p), 32'(exp_p));
   end

   // One full operation: accept, measure latency, check product, optional hold, then take it.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [PW-1:0] exp, input int hold, input string name);
      int lat;
      in_valid = 1'b1;
      x = a;
      y = b;
      sgn = s;
      @(posedge clk); #1;
      in_valid = 1'b0;
      x = 8'($urandom);
      y = 8'($urandom);
      sgn = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({name, "_latency"}, 32'(lat), 32'(PW));
      chk({name, "_p"}, 32'(p), 32'(exp));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({name, "_hold"}, {29'd0, out_valid, in_ready, (p == exp)}, 32'b101);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({name, "_release"}, {30'd0, in_ready, out_valid}, 32'b10);
   endtask

   initial begin
      int ov_seen;
      rst = 1'b0;
      in_valid = 1'b0;
      x = '0;
      y = '0;
      sgn = 1'b0;
      clr = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", {13'd0, in_ready, out_valid, p}, {13'd0, 1'b1, 1'b0, 16'h0000});
      rst = 1'b1;

      // Unsigned and mixed vectors.
      run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, 0, "uns_ff_ff");
      run_op(8'h00, 8'hAB, 1'b0, 16'h0000, 0, "uns_zero");
      run_op(8'hA5, 8'h5A, 1'b0, 16'h3A02, 0, "uns_a5_5a");
      run_op(8'h80, 8'h80, 1'b1, 16'h4000, 0, "sgn_80_80");
      run_op(8'hFF, 8'h01, 1'b1, SIGNED_BUILD ? 16'hFFFF : 16'h00FF, 0, "sgn_ff_01");
      run_op(8'hFF, 8'hFF, 1'b1, SIGNED_BUILD ? 16'h0001 : 16'hFE01, 0, "sgn_ff_ff");
      run_op(8'h7F, 8'h80, 1'b1, SIGNED_BUILD ? 16'hC080 : 16'h3F80, 0, "sgn_7f_80");
      run_op(8'hA5, 8'h5A, 1'b1, SIGNED_BUILD ? 16'hE002 : 16'h3A02, 0, "sgn_a5_5a");

      // Backpressure: product held for 20 cycles.
      run_op(8'h12, 8'h34, 1'b0, 16'h03A8, 20, "backpressure");

      // Abort at RUN cycle 5 with a simultaneous in_valid.
      in_valid = 1'b1;
      x = 8'h55;
      y = 8'hAA;
      sgn = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      clr = 1'b1;
      in_valid = 1'b1;
      x = 8'h11;
      y = 8'h22;
      @(posedge clk); #1;
      clr = 1'b0;
      in_valid = 1'b0;
      chk("abort_state", {13'd0, in_ready, out_valid, p}, {13'd0, 1'b1, 1'b0, 16'h0000});
      ov_seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (out_valid) ov_seen++;
      end
      chk("abort_no_valid", 32'(ov_seen), 32'd0);
      run_op(8'h03, 8'h05, 1'b0, 16'h000F, 0, "after_abort");

      // Reset asserted at RUN cycle 9.
      in_valid = 1'b1;
      x = 8'hC3;
      y = 8'h3C;
      sgn = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
      end
      rst = 1'b0;
      #1;
      chk("midrun_reset", {13'd0, in_ready, out_valid, p}, {13'd0, 1'b1, 1'b0, 16'h0000});
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      run_op(8'h7F, 8'h02, 1'b0, 16'h00FE, 0, "after_reset");

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop in case the run never reaches its summary.
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/spm_mul.md
SPM_MUL -- requirements
Module: spm_mul

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter PW, default 2*WIDTH, product width; it is derived and SHALL NOT be overridden.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 The block SHALL have port x, input, WIDTH bits: parallel multiplicand.
REQ-008 The block SHALL have port y, input, WIDTH bits: multiplier, consumed serially LSB-first.
REQ-009 The block SHALL have port sgn, input, 1 bit: 1 = two's-complement operands, 0 = unsigned.
REQ-010 The block SHALL have port clr, input, 1 bit: synchronous abort.
REQ-011 The block SHALL have port out_valid, output, 1 bit: product available.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer takes product.
REQ-013 The block SHALL have port p, output, PW bits: registered product.

Function
REQ-014 The block SHALL use three states: IDLE, RUN and DONE. in_ready SHALL equal (state==IDLE), and out_valid SHALL equal (state==DONE).
REQ-015 In IDLE, when in_valid is high, the block SHALL capture x, y and sgn, clear the accumulator and the cycle counter, and enter RUN on the next edge.
REQ-016 RUN SHALL last exactly PW cycles. Each cycle SHALL consume one multiplier bit: y[0..WIDTH-1], then y[WIDTH-1] (sign extension) when sgn=1, or 0 when sgn=0.
REQ-017 The multiplicand SHALL be sign-extended to PW bits when sgn=1 and zero-extended otherwise.
REQ-018 Accumulation SHALL be carry-save per bit, with one bit-cell per multiplicand bit as in a serial-parallel array. The product bits SHALL be shifted into p LSB-first, and the result SHALL be correct modulo 2^PW.
REQ-019 The accept edge SHALL be edge k. out_valid SHALL rise after edge k+PW, and p SHALL be stable for as long as out_valid is high.
REQ-020 In DONE, when out_ready is high, the block SHALL return to IDLE on the next edge. While out_ready is low, p and out_valid SHALL hold indefinitely.
REQ-021 There SHALL be no overlap: no operand is accepted until the product has been taken, so throughput is one product per PW+2 cycles minimum.
REQ-022 clr SHALL take priority over all other inputs in every state. It SHALL force IDLE and zero the accumulator, counter and p on the next edge. An in_valid on the same cycle SHALL be ignored.
REQ-023 Changes on x, y or sgn after the accept edge SHALL have no effect on the result in progress.
REQ-024 The cycle counter SHALL be clog2(PW)+1 bits wide and SHALL never wrap within a run.

Reset
REQ-025 While rst is low, the block SHALL be in state IDLE, with p=0, the accumulator, carries and counter =0, in_ready=1 and out_valid=0.
REQ-026 Reset assertion mid-RUN or in DONE SHALL discard the operation with no output pulse.
REQ-027 Reset deassertion SHALL be synchronised externally; the block SHALL accept operands from the first edge after deassertion.

Configuration
REQ-028 Macro SPM_SIGNED_EN defined: the sgn input SHALL be honoured as in REQ-016 and REQ-017.
REQ-029 Macro SPM_SIGNED_EN undefined: sgn SHALL be ignored, all operations SHALL be unsigned, and the sign-extension logic SHALL be absent. The port SHALL remain present.

Structure
REQ-030 Package spm_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-031 Sub-module spm_cell SHALL be one carry-save bit-cell (registered sum and carry, active-low async reset, synchronous clear), instantiated WIDTH times by a generate loop.
REQ-032 The sequencer FSM, counter and output shift register SHALL reside in spm_mul.

Verification (WIDTH=8)
REQ-033 The bench SHALL cover unsigned: sgn=0, x=0xFF, y=0xFF -> p=0xFE01, with out_valid 16 cycles after accept.
REQ-034 The bench SHALL cover signed: sgn=1, x=0x80, y=0x80 -> p=0x4000; and x=0xFF, y=0x01 -> p=0xFFFF.
REQ-035 The bench SHALL cover backpressure: out_ready held low for 20 cycles -> p and out_valid steady, in_ready=0 throughout; release -> IDLE on the next edge.
REQ-036 The bench SHALL cover abort: clr pulsed at RUN cycle 5 together with in_valid -> IDLE, p=0, no out_valid. The next operation, 0x03*0x05, SHALL give p=0x000F.
REQ-037 The bench SHALL cover reset mid-run: rst low at RUN cycle 9 -> all outputs at reset values immediately. After release, 0x7F*0x02 SHALL give p=0x00FE.
REQ-038 The bench SHALL cover the macro: with SPM_SIGNED_EN undefined, sgn=1, x=0x80, y=0x80 -> p=0x4000 (unsigned 128*128). With x=0xFF, y=0xFF -> p=0xFE01.
